// File: rtl/tag_free_ctrl_if.sv
// tag_free_ctrl_if: dispatch, return and tag-FIFO signals of the tag free-list controller
interface tag_free_ctrl_if #(
   parameter int TAG_WIDTH = 6,
   parameter int DEPTH     = 64,
   parameter int N_RET     = 4
);
   logic                       flush;
   logic                       alloc_req;
   logic                       alloc_gnt;
   logic [TAG_WIDTH-1:0]       alloc_tag;
   logic [N_RET-1:0]           ret_valid;
   logic [N_RET*TAG_WIDTH-1:0] ret_tag;
   logic [N_RET-1:0]           ret_ack;
   logic                       tf_rd_en;
   logic [TAG_WIDTH-1:0]       tf_tag_out;
   logic                       tf_empty;
   logic                       tf_full;
   logic                       tf_wr_valid;
   logic [TAG_WIDTH-1:0]       tf_wr_tag;
   logic                       tf_flush;
   logic [$clog2(DEPTH):0]     free_count;
   logic                       low_tags;
   logic                       err;
   modport slave (
      input  flush, alloc_req, ret_valid, ret_tag, tf_tag_out, tf_empty, tf_full,
      output alloc_gnt, alloc_tag, ret_ack, tf_rd_en, tf_wr_valid, tf_wr_tag, tf_flush,
             free_count, low_tags, err
   );
   modport master (
      output flush, alloc_req, ret_valid, ret_tag, tf_tag_out, tf_empty, tf_full,
      input  alloc_gnt, alloc_tag, ret_ack, tf_rd_en, tf_wr_valid, tf_wr_tag, tf_flush,
             free_count, low_tags, err
   );
endinterface

// File: rtl/tag_free_ctrl.sv
// tag_free_ctrl: zero-latency tag allocation from a free-tag FIFO with round-robin tag returns
module tag_free_ctrl #(
   parameter int TAG_WIDTH = 6,
   parameter int DEPTH     = 64,
   parameter int N_RET     = 4,
   parameter int LOW_WM    = 4
) (
   input logic            i_clk,
   input logic            i_rst_n,
   tag_free_ctrl_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = N_RET > 1 ? $clog2(N_RET) : 1;
   typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;
   state_t          state;
   logic [CW-1:0]   fc;
   logic [RW-1:0]   rr_ptr;
   logic [RW-1:0]   gidx;
   logic [RW-1:0]   j;
   logic            found;
   logic            err_q;
   logic            run_ok;
   logic            push;
   logic            pop;
   logic            fc_full;
   assign run_ok  = state == RUN && !bus.flush;
   assign fc_full = fc == CW'(DEPTH);
   assign pop     = bus.alloc_req && run_ok && !bus.tf_empty && fc != '0;
   assign push    = found && run_ok && !bus.tf_full;
   // first valid requester at or after rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      j     = '0;
      for (int k = 0; k < N_RET; k++) begin
         j = RW'((int'(rr_ptr) + k) % N_RET);
         if (!found && bus.ret_valid[j]) begin
            found = 1'b1;
            gidx  = j;
         end
      end
   end
   assign bus.alloc_gnt   = pop;
   assign bus.tf_rd_en    = pop;
   assign bus.alloc_tag   = pop ? bus.tf_tag_out : '0;
   assign bus.ret_ack     = push ? N_RET'(1) << gidx : '0;
   assign bus.tf_wr_valid = push;
   assign bus.tf_wr_tag   = push ? bus.ret_tag[int'(gidx)*TAG_WIDTH +: TAG_WIDTH] : '0;
   assign bus.tf_flush    = bus.flush;
   assign bus.free_count  = fc;
   assign bus.low_tags    = fc <= CW'(LOW_WM);
   assign bus.err         = err_q;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= INIT;
         fc     <= CW'(DEPTH);
         rr_ptr <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state != INIT && bus.flush ? FLUSH : RUN;
         fc     <= bus.flush      ? CW'(DEPTH) :
                   push && !pop   ? (fc_full ? fc : fc + 1'b1) :
                   pop && !push   ? (fc == '0 ? fc : fc - 1'b1) : fc;
         rr_ptr <= bus.flush ? '0 :
                   push      ? (int'(gidx) == N_RET - 1 ? '0 : gidx + 1'b1) : rr_ptr;
         err_q  <= err_q || (push && fc_full) || (pop && fc == '0) ||
                   (bus.tf_empty && fc_full && state == RUN);
      end
   end
endmodule

// File: tb/tb_tag_free_ctrl.sv
// tb_tag_free_ctrl: directed vectors with hand-computed expectations for tag_free_ctrl
module tb_tag_free_ctrl;
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   int   vecs = 0;
   int   miscompares = 0;
   always #5 i_clk = ~i_clk;
   tag_free_ctrl_if #(.TAG_WIDTH(6), .DEPTH(64), .N_RET(4)) bus ();
   tag_free_ctrl #(.TAG_WIDTH(6), .DEPTH(64), .N_RET(4), .LOW_WM(4)) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .bus    (bus.slave)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask
   initial begin
      bus.flush      = 1'b0;
      bus.alloc_req  = 1'b1;
      bus.ret_valid  = 4'b0001;
      bus.ret_tag    = {6'd13, 6'd12, 6'd11, 6'd10};
      bus.tf_tag_out = 6'd0;
      bus.tf_empty   = 1'b0;
      bus.tf_full    = 1'b0;
      #12;
      chk("rst_gnt", bus.alloc_gnt, 0);
      chk("rst_rd_en", bus.tf_rd_en, 0);
      chk("rst_ack", bus.ret_ack, 0);
      chk("rst_wr_valid", bus.tf_wr_valid, 0);
      chk("rst_fc", bus.free_count, 64);
      chk("rst_err", bus.err, 0);
      chk("rst_low", bus.low_tags, 0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      #1;
      chk("init_gnt", bus.alloc_gnt, 0);
      chk("init_ack", bus.ret_ack, 0);
      bus.ret_valid = 4'b0000;
      tick();
      for (int t = 0; t < 3; t++) begin
         bus.tf_tag_out = 6'(t);
         #1;
         chk("alloc_gnt", bus.alloc_gnt, 1);
         chk("alloc_rd_en", bus.tf_rd_en, 1);
         chk("alloc_tag", bus.alloc_tag, t);
         tick();
         chk("alloc_fc", bus.free_count, 63 - t);
      end
      for (int i = 0; i < 57; i++) begin
         bus.tf_tag_out = 6'(i + 3);
         #1;
         chk("drain_gnt", bus.alloc_gnt, 1);
         if (i == 56) chk("low_at_5", bus.low_tags, 0);
         tick();
      end
      chk("drain_fc", bus.free_count, 4);
      chk("low_at_4", bus.low_tags, 1);
      bus.tf_empty = 1'b1;
      #1;
      chk("empty_gnt", bus.alloc_gnt, 0);
      chk("empty_rd_en", bus.tf_rd_en, 0);
      chk("empty_tag", bus.alloc_tag, 0);
      tick();
      chk("empty_fc", bus.free_count, 4);
      chk("empty_err", bus.err, 0);
      bus.tf_empty  = 1'b0;
      bus.alloc_req = 1'b0;
      bus.ret_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_ack", bus.ret_ack, 1 << k);
         chk("rr_wr_valid", bus.tf_wr_valid, 1);
         chk("rr_wr_tag", bus.tf_wr_tag, 10 + k);
         tick();
         chk("rr_fc", bus.free_count, 5 + k);
      end
      bus.tf_full   = 1'b1;
      bus.ret_valid = 4'b0001;
      #1;
      chk("full_ack", bus.ret_ack, 0);
      chk("full_wr_valid", bus.tf_wr_valid, 0);
      tick();
      chk("full_fc", bus.free_count, 8);
      bus.tf_full    = 1'b0;
      bus.alloc_req  = 1'b1;
      bus.tf_tag_out = 6'd7;
      #1;
      chk("both_rd_en", bus.tf_rd_en, 1);
      chk("both_tag", bus.alloc_tag, 7);
      chk("both_wr_valid", bus.tf_wr_valid, 1);
      chk("both_wr_tag", bus.tf_wr_tag, 10);
      tick();
      chk("both_fc", bus.free_count, 8);
      bus.flush     = 1'b1;
      bus.ret_valid = 4'b0010;
      #1;
      chk("fl_tf_flush", bus.tf_flush, 1);
      chk("fl_gnt", bus.alloc_gnt, 0);
      chk("fl_ack", bus.ret_ack, 0);
      chk("fl_wr_valid", bus.tf_wr_valid, 0);
      tick();
      bus.flush = 1'b0;
      #1;
      chk("fls_tf_flush", bus.tf_flush, 0);
      chk("fls_gnt", bus.alloc_gnt, 0);
      chk("fls_ack", bus.ret_ack, 0);
      chk("fls_fc", bus.free_count, 64);
      tick();
      bus.ret_valid = 4'b0000;
      #1;
      chk("post_fl_gnt", bus.alloc_gnt, 1);
      tick();
      chk("post_fl_fc", bus.free_count, 63);
      bus.alloc_req = 1'b0;
      bus.ret_valid = 4'b0011;
      #1;
      chk("rr_reset_ack", bus.ret_ack, 4'b0001);
      tick();
      chk("ret_fc", bus.free_count, 64);
      chk("pre_err", bus.err, 0);
      bus.ret_valid = 4'b0001;
      #1;
      chk("over_ack", bus.ret_ack, 4'b0001);
      tick();
      bus.ret_valid = 4'b0000;
      chk("over_err", bus.err, 1);
      chk("over_fc", bus.free_count, 64);
      tick();
      tick();
      chk("err_sticky", bus.err, 1);
      bus.alloc_req  = 1'b1;
      bus.tf_tag_out = 6'd5;
      #1;
      chk("pre_rst_gnt", bus.alloc_gnt, 1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", bus.alloc_gnt, 0);
      chk("mid_rst_rd_en", bus.tf_rd_en, 0);
      chk("mid_rst_err", bus.err, 0);
      chk("mid_rst_fc", bus.free_count, 64);
      tick();
      chk("held_rst_fc", bus.free_count, 64);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
